if_stage: RTL and testbench

Instruction-fetch front end: PC register, synchronous instruction-memory request, IF/ID pipeline register. It consumes the stall vector from the load-use hazard detector and the branch flush from EX. A one-entry skid buffer captures the fetch that is in flight when a stall begins, so stall release costs no extra bubble. Sits between instruction memory and the ID stage.

---
 rtl/if_stage_pkg.sv | 39 +++
 rtl/fetch_skid_buf.sv | 33 +++
 rtl/if_stage.sv | 135 +++++++++++++
 tb/tb_if_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: stall-vector bit macros, instruction constants, entry type.
// The stall macros here are the ones the hazard unit and the fetch stage both decode.
`ifndef IF_STAGE_DEFINES
`define IF_STAGE_DEFINES
`define STALL_WIDTH 2
`define STALL_PC 0
`define STALL_IF 1
`define STALL_NOP 2'b00
`define STALL_LOAD 2'b11
`define INST_NOP 32'h0000_0013
`define INST_ADDR_WIDTH 32
`endif

package if_stage_pkg;

  localparam int unsigned AddrWidth  = `INST_ADDR_WIDTH;
  localparam int unsigned InstWidth  = 32;
  localparam int unsigned StallWidth = `STALL_WIDTH;
  localparam int unsigned StallPcBit = `STALL_PC;
  localparam int unsigned StallIfBit = `STALL_IF;

  localparam logic [StallWidth-1:0] StallNop  = `STALL_NOP;
  localparam logic [StallWidth-1:0] StallLoad = `STALL_LOAD;

  typedef struct packed {
    logic [AddrWidth-1:0] pc;
    logic [InstWidth-1:0] inst;
  } fetch_entry_t;

  // Sequential PC; wraps 32'hFFFF_FFFC -> 0 through natural overflow.
  function automatic logic [AddrWidth-1:0] pc_incr(input logic [AddrWidth-1:0] pc);
    return pc + AddrWidth'(4);
  endfunction

  function automatic logic [AddrWidth-1:0] pc_align(input logic [AddrWidth-1:0] addr);
    return {addr[AddrWidth-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} holding register for the fetch in flight when a stall begins.
// Clear has priority over load; the caller decides when a load is allowed.
module fetch_skid_buf
  import if_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t load_entry,
  output fetch_entry_t entry,
  output logic         valid
);

  fetch_entry_t entry_q;
  logic         valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      entry_q <= load_entry;
      valid_q <= 1'b1;
    end
  end

  assign entry = entry_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, synchronous imem request, IF/ID register, skid buffer.
// Define IF_PERF_CNT_EN to add saturating stall_cycles / flush_count outputs.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [AddrWidth-1:0] RESET_PC = '0,
  parameter logic [InstWidth-1:0] NOP_INST = `INST_NOP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`STALL_WIDTH-1:0] stall,
  input  logic                   flush_ex,
  input  logic [AddrWidth-1:0]   target_ex,
  output logic [AddrWidth-1:0]   inst_addr,
  output logic                   inst_req,
  input  logic [InstWidth-1:0]   inst_rdata,
  output logic [AddrWidth-1:0]   pc_id,
  output logic [InstWidth-1:0]   inst_id,
  output logic                   valid_id
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            flush_count
`endif
);

  logic stall_pc;
  logic stall_if;
  assign stall_pc = stall[`STALL_PC];
  assign stall_if = stall[`STALL_IF];

  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [AddrWidth-1:0] fetch_pc_q;
  logic                 fetch_vld_q, fetch_vld_d;
  fetch_entry_t         id_q, id_d;
  logic                 valid_id_q, valid_id_d;

  logic         skid_load;
  logic         skid_clear;
  logic         skid_vld;
  fetch_entry_t skid_entry;
  fetch_entry_t fetch_entry;

  // Low address bits are ignored; the redirect is always word aligned.
  logic unused_target_bits;
  assign unused_target_bits = ^target_ex[1:0];

  assign inst_req    = ~rst & ~flush_ex & ~stall_pc;
  assign inst_addr   = pc_q;
  assign fetch_entry = '{pc: fetch_pc_q, inst: inst_rdata};

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_entry (fetch_entry),
    .entry      (skid_entry),
    .valid      (skid_vld)
  );

  always_comb begin
    pc_d        = pc_q;
    fetch_vld_d = 1'b0;
    id_d        = id_q;
    valid_id_d  = valid_id_q;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    if (flush_ex) begin
      pc_d       = pc_align(target_ex);
      id_d       = '{pc: '0, inst: NOP_INST};
      valid_id_d = 1'b0;
      skid_clear = 1'b1;
    end else if (stall_if) begin
      // Capture only the first in-flight fetch; later stall cycles keep it.
      skid_load = fetch_vld_q & ~skid_vld;
    end else begin
      if (!stall_pc) begin
        pc_d = pc_incr(pc_q);
      end
      fetch_vld_d = ~stall_pc;
      skid_clear  = 1'b1;
      if (skid_vld) begin
        id_d       = skid_entry;
        valid_id_d = 1'b1;
      end else begin
        id_d       = fetch_entry;
        valid_id_d = fetch_vld_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      fetch_pc_q  <= '0;
      fetch_vld_q <= 1'b0;
      id_q        <= '{pc: '0, inst: NOP_INST};
      valid_id_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      fetch_pc_q  <= pc_q;
      fetch_vld_q <= fetch_vld_d;
      id_q        <= id_d;
      valid_id_q  <= valid_id_d;
    end
  end

  assign pc_id    = id_q.pc;
  assign inst_id  = id_q.inst;
  assign valid_id = valid_id_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (flush_ex && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
      if (!flush_ex && stall_if && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: an instruction-stream model predicts each IF/ID update,
// a separate monitor pops and compares after every clock edge.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic                  clk;
  logic                  rst;
  logic [StallWidth-1:0] stall;
  logic                  flush_ex;
  logic [31:0]           target_ex;
  logic [31:0]           inst_addr;
  logic                  inst_req;
  logic [31:0]           inst_rdata;
  logic [31:0]           pc_id;
  logic [31:0]           inst_id;
  logic                  valid_id;
`ifdef IF_PERF_CNT_EN
  logic [31:0]           stall_cycles;
  logic [31:0]           flush_count;
`endif

  if_stage #(
    .RESET_PC (ResetPc),
    .NOP_INST (Nop)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush_ex     (flush_ex),
    .target_ex    (target_ex),
    .inst_addr    (inst_addr),
    .inst_req     (inst_req),
    .inst_rdata   (inst_rdata),
    .pc_id        (pc_id),
    .inst_id      (inst_id),
    .valid_id     (valid_id)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        full;   // pc/inst are meaningful and compared
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: next in-order pc, bubbles still owed before it, and current IF/ID view.
  logic [31:0] nxt;
  int          bub;
  exp_t        cur;
  logic [31:0] sc_model;
  logic [31:0] fc_model;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_0013;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Synchronous instruction memory: data for last cycle's request, garbage otherwise.
  always @(posedge clk) inst_rdata <= inst_req ? mem_word(inst_addr) : $urandom;

  task automatic model_reset();
    cur      = '{pc: 32'h0, inst: Nop, valid: 1'b0, full: 1'b1};
    bub      = 1;
    nxt      = ResetPc;
    sc_model = '0;
    fc_model = '0;
  endtask

  task automatic cycle(input logic r, input logic f, input logic [31:0] tgt,
                       input logic [StallWidth-1:0] st);
    logic req_exp;
    @(negedge clk);
    rst       = r;
    flush_ex  = f;
    target_ex = tgt;
    stall     = st;
    if (r) begin
      model_reset();
    end else if (f) begin
      cur      = '{pc: 32'h0, inst: Nop, valid: 1'b0, full: 1'b1};
      nxt      = tgt & ~32'h3;
      bub      = 1;
      fc_model = sat_inc(fc_model);
    end else if (st[StallIfBit]) begin
      sc_model = sat_inc(sc_model);
    end else begin
      if (bub > 0) begin
        cur.valid = 1'b0;
        cur.full  = 1'b0;
        bub--;
      end else begin
        cur = '{pc: nxt, inst: mem_word(nxt), valid: 1'b1, full: 1'b1};
        nxt = nxt + 32'd4;
      end
      // No request this cycle means one more empty slot downstream.
      if (st[StallPcBit]) bub++;
    end
    exp_q.push_back(cur);
    #1;
    req_exp = !r && !f && !st[StallPcBit];
    check("inst_req", {31'b0, inst_req}, {31'b0, req_exp});
    if (r) begin
      check("rst_pc_id", pc_id, 32'h0);
      check("rst_inst_id", inst_id, Nop);
      check("rst_valid_id", {31'b0, valid_id}, 32'h0);
      check("rst_inst_addr", inst_addr, ResetPc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, StallNop);
  endtask

  // Monitor: IF/ID updates on every edge, so every edge consumes one expectation.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: no expectation queued at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("valid_id", {31'b0, valid_id}, {31'b0, e.valid});
        if (e.full) begin
          check("pc_id", pc_id, e.pc);
          check("inst_id", inst_id, e.inst);
        end
      end
    end
  end

  initial begin
    logic [StallWidth-1:0] st;
    logic [StallWidth-1:0] st_pc_only;
    logic [StallWidth-1:0] st_if_only;
    int stall_left;
    st_pc_only             = '0;
    st_pc_only[StallPcBit] = 1'b1;
    st_if_only             = '0;
    st_if_only[StallIfBit] = 1'b1;

    rst       = 1'b0;
    flush_ex  = 1'b0;
    target_ex = '0;
    stall     = StallNop;
    model_reset();
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid_id", {31'b0, valid_id}, 32'h0);
    check("async_rst_inst_id", inst_id, Nop);
    check("async_rst_inst_addr", inst_addr, ResetPc);

    cycle(1'b1, 1'b0, 32'h0, StallNop);
    cycle(1'b1, 1'b0, 32'h0, StallNop);

    // Reset release: sequential addresses.
    cycle(1'b0, 1'b0, 32'h0, StallNop);
    check("addr_0", inst_addr, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, StallNop);
    check("addr_4", inst_addr, 32'h4);
    cycle(1'b0, 1'b0, 32'h0, StallNop);
    check("addr_8", inst_addr, 32'h8);
    idle(3);

    // One-cycle and three-cycle load-use stalls.
    cycle(1'b0, 1'b0, 32'h0, StallLoad);
    idle(3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, StallLoad);
    idle(3);

    // Branch redirect.
    cycle(1'b0, 1'b1, 32'h0000_0102, StallNop);
    cycle(1'b0, 1'b0, 32'h0, StallNop);
    check("flush_addr", inst_addr, 32'h100);
    idle(3);

    // Flush and stall together while the skid holds an entry.
    cycle(1'b0, 1'b0, 32'h0, StallLoad);
    cycle(1'b0, 1'b1, 32'h0000_0204, StallLoad);
    cycle(1'b0, 1'b0, 32'h0, StallNop);
    check("flush_stall_addr", inst_addr, 32'h204);
    idle(3);

    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, StallNop);
    cycle(1'b0, 1'b0, 32'h0, StallNop);
    check("wrap_addr_top", inst_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, StallNop);
    check("wrap_addr_zero", inst_addr, 32'h0);
    idle(3);

    // Async reset in the middle of a stall with the skid loaded.
    cycle(1'b0, 1'b0, 32'h0, StallLoad);
    cycle(1'b0, 1'b0, 32'h0, StallLoad);
    cycle(1'b1, 1'b0, 32'h0, StallLoad);
    cycle(1'b1, 1'b0, 32'h0, StallNop);
    idle(4);

    // Randomized traffic.
    stall_left = 0;
    for (int i = 0; i < 1500; i++) begin
      int roll;
      roll = int'($urandom_range(0, 99));
      st   = StallNop;
      if (stall_left > 0) begin
        st = StallLoad;
        stall_left--;
      end else if (roll < 15) begin
        st         = StallLoad;
        stall_left = int'($urandom_range(0, 3));
      end else if (roll < 18) begin
        st = st_pc_only;
      end else if (roll < 21) begin
        st = st_if_only;
      end
      cycle(1'b0, ($urandom_range(0, 19) == 0), $urandom, st);
    end
    idle(2);

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 32'h0);
`ifdef IF_PERF_CNT_EN
    check("stall_cycles", stall_cycles, sc_model);
    check("flush_count", flush_count, fc_model);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
